// File: rtl/byte_striping.sv
// byte_striping: deals a single clk_2f-rate byte stream alternately onto two
// half-rate stripe lanes (lane 0 = even bytes, lane 1 = odd bytes).
// Ports:
//   clk_2f          fast-rate clock, all state on its rising edge
//   reset_L         asynchronous active-low reset
//   data_in/valid_in  input byte and qualifier (no backpressure)
//   data_stripe_0/1   lane 0 / lane 1 bytes, updated only on emit edges
//   valid_stripe_0/1  lane 0 / lane 1 qualifiers
module byte_striping #(
  parameter int unsigned FLUSH_TIMEOUT = 4
) (
  input  logic       clk_2f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_stripe_0,
  output logic [7:0] data_stripe_1,
  output logic       valid_stripe_0,
  output logic       valid_stripe_1
);

  localparam int unsigned IDLE_W = 4;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT);

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  logic              phase;
  logic              sel, sel_nxt;
  logic [7:0]        asm0, asm0_nxt;
  logic [IDLE_W-1:0] idle, idle_nxt;
  logic              pend_full, pend_full_nxt;
  logic [7:0]        pend0, pend0_nxt;
  logic [7:0]        pend1, pend1_nxt;
  logic [7:0]        d0_nxt, d1_nxt;
  logic              v0_nxt, v1_nxt;
  logic              pair_done;
  logic              flush_due;

  // State register; phase is high before every emit edge.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      phase          <= 1'b0;
      sel            <= LANE0;
      asm0           <= 8'd0;
      idle           <= '0;
      pend_full      <= 1'b0;
      pend0          <= 8'd0;
      pend1          <= 8'd0;
      data_stripe_0  <= 8'd0;
      data_stripe_1  <= 8'd0;
      valid_stripe_0 <= 1'b0;
      valid_stripe_1 <= 1'b0;
    end else begin
      phase          <= ~phase;
      sel            <= sel_nxt;
      asm0           <= asm0_nxt;
      idle           <= idle_nxt;
      pend_full      <= pend_full_nxt;
      pend0          <= pend0_nxt;
      pend1          <= pend1_nxt;
      data_stripe_0  <= d0_nxt;
      data_stripe_1  <= d1_nxt;
      valid_stripe_0 <= v0_nxt;
      valid_stripe_1 <= v1_nxt;
    end
  end

  // Next-state: pair assembly, pending slot and emit-edge output selection.
  always_comb begin
    sel_nxt       = sel;
    asm0_nxt      = asm0;
    idle_nxt      = idle;
    pend_full_nxt = pend_full;
    pend0_nxt     = pend0;
    pend1_nxt     = pend1;
    d0_nxt        = data_stripe_0;
    d1_nxt        = data_stripe_1;
    v0_nxt        = valid_stripe_0;
    v1_nxt        = valid_stripe_1;

    pair_done = (sel == LANE1) && valid_in;
    flush_due = (sel == LANE1) && !valid_in && (idle >= IDLE_MAX);

    case (sel)
      LANE0: begin
        if (valid_in) begin
          asm0_nxt = data_in;
          sel_nxt  = LANE1;
          idle_nxt = '0;
        end
      end
      default: begin
        if (valid_in) begin
          sel_nxt  = LANE0;
          idle_nxt = '0;
        end else if (idle < IDLE_MAX) begin
          idle_nxt = idle + IDLE_W'(1);
        end
      end
    endcase

    if (!phase) begin
      // Non-emit edge: outputs hold; a completed pair parks in pending.
      if (pair_done) begin
        pend0_nxt     = asm0;
        pend1_nxt     = data_in;
        pend_full_nxt = 1'b1;
      end
    end else if (pend_full) begin
      d0_nxt = pend0;
      d1_nxt = pend1;
      v0_nxt = 1'b1;
      v1_nxt = 1'b1;
      if (pair_done) begin
        pend0_nxt = asm0;
        pend1_nxt = data_in;
      end else begin
        pend_full_nxt = 1'b0;
      end
    end else if (pair_done) begin
      d0_nxt = asm0;
      d1_nxt = data_in;
      v0_nxt = 1'b1;
      v1_nxt = 1'b1;
    end else if (flush_due) begin
      // Lone lane-0 byte gave up waiting; lane 1 data is left as it was.
      d0_nxt   = asm0;
      v0_nxt   = 1'b1;
      v1_nxt   = 1'b0;
      sel_nxt  = LANE0;
      idle_nxt = '0;
    end else begin
      v0_nxt = 1'b0;
      v1_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: fixed byte sequences with hand-computed
// lane outputs sampled 1 time unit after each rising edge.
module tb_byte_striping;

  logic       clk_2f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_stripe_0;
  logic [7:0] data_stripe_1;
  logic       valid_stripe_0;
  logic       valid_stripe_1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_2f = ~clk_2f;

  byte_striping #(.FLUSH_TIMEOUT(4)) dut (
    .clk_2f         (clk_2f),
    .reset_L        (reset_L),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .data_stripe_0  (data_stripe_0),
    .data_stripe_1  (data_stripe_1),
    .valid_stripe_0 (valid_stripe_0),
    .valid_stripe_1 (valid_stripe_1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packs {valid0, valid1, stripe0, stripe1} into one comparison.
  task automatic chk_out(input string tag, input logic v0, input logic v1,
                         input logic [7:0] d0, input logic [7:0] d1);
    check(tag, {14'd0, valid_stripe_0, valid_stripe_1, data_stripe_0, data_stripe_1},
               {14'd0, v0, v1, d0, d1});
  endtask

  // Present one input cycle, then sample just after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  // Released 1 unit after an edge, so the next rising edge is edge 1.
  task automatic do_reset();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'd0;
    @(posedge clk_2f);
    #1;
    chk_out("reset_state", 1'b0, 1'b0, 8'h00, 8'h00);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'd0;

    // Bytes arriving on odd edges: bypass on every emit edge.
    do_reset();
    step(1'b1, 8'h11); chk_out("t1_e1", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h22); chk_out("t1_e2", 1'b1, 1'b1, 8'h11, 8'h22);
    step(1'b1, 8'h33); chk_out("t1_e3", 1'b1, 1'b1, 8'h11, 8'h22);
    step(1'b1, 8'h44); chk_out("t1_e4", 1'b1, 1'b1, 8'h33, 8'h44);
    step(1'b0, 8'h00); chk_out("t1_e5", 1'b1, 1'b1, 8'h33, 8'h44);
    step(1'b0, 8'h00); chk_out("t1_e6", 1'b0, 1'b0, 8'h33, 8'h44);

    // Bytes starting on an even edge: pairs go through pending.
    do_reset();
    step(1'b0, 8'h00); chk_out("t2_e1", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h11); chk_out("t2_e2", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h22); chk_out("t2_e3", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h33); chk_out("t2_e4", 1'b1, 1'b1, 8'h11, 8'h22);
    step(1'b1, 8'h44); chk_out("t2_e5", 1'b1, 1'b1, 8'h11, 8'h22);
    step(1'b0, 8'h00); chk_out("t2_e6", 1'b1, 1'b1, 8'h33, 8'h44);
    step(1'b0, 8'h00); chk_out("t2_e7", 1'b1, 1'b1, 8'h33, 8'h44);
    step(1'b0, 8'h00); chk_out("t2_e8", 1'b0, 1'b0, 8'h33, 8'h44);

    // Lone lane-0 byte flushed after the timeout; lane 1 data held.
    do_reset();
    step(1'b1, 8'h10);
    step(1'b1, 8'h20); chk_out("t3_e2", 1'b1, 1'b1, 8'h10, 8'h20);
    step(1'b1, 8'hAA);
    step(1'b0, 8'h00); chk_out("t3_e4", 1'b0, 1'b0, 8'h10, 8'h20);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00); chk_out("t3_e6_noflush", 1'b0, 1'b0, 8'h10, 8'h20);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00); chk_out("t3_e8_flush", 1'b1, 1'b0, 8'hAA, 8'h20);
    step(1'b1, 8'hBB); chk_out("t3_e9", 1'b1, 1'b0, 8'hAA, 8'h20);
    step(1'b1, 8'hCC); chk_out("t3_e10", 1'b1, 1'b1, 8'hBB, 8'hCC);

    // Gap shorter than the timeout still pairs.
    do_reset();
    step(1'b1, 8'h01);
    step(1'b0, 8'h00); chk_out("t4_e2", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00);
    step(1'b1, 8'h02); chk_out("t4_e4", 1'b1, 1'b1, 8'h01, 8'h02);

    // Full rate: 64 back-to-back bytes, a pair on every emit edge.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 8'(i));
      if (i % 2 == 1)
        chk_out($sformatf("t5_pair%0d", i / 2), 1'b1, 1'b1, 8'(i - 1), 8'(i));
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00); chk_out("t5_drain", 1'b0, 1'b0, 8'h3E, 8'h3F);

    // Reset with a pair pending: outputs clear at once, stale pair lost.
    do_reset();
    step(1'b1, 8'h01);
    step(1'b1, 8'h02); chk_out("t6_e2", 1'b1, 1'b1, 8'h01, 8'h02);
    step(1'b0, 8'h00);
    step(1'b1, 8'h03); chk_out("t6_e4", 1'b0, 1'b0, 8'h01, 8'h02);
    step(1'b1, 8'h04); chk_out("t6_e5", 1'b0, 1'b0, 8'h01, 8'h02);
    valid_in = 1'b0;
    #2 reset_L = 1'b0;
    #1 chk_out("t6_async_clear", 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk_2f);
    #1;
    reset_L = 1'b1;
    step(1'b1, 8'h55); chk_out("t6_r_e1", 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h66); chk_out("t6_r_e2", 1'b1, 1'b1, 8'h55, 8'h66);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00); chk_out("t6_r_e4", 1'b0, 1'b0, 8'h55, 8'h66);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
